// File: rtl/hdma_trigger_gen_if.sv
// hdma_trigger_gen_if
//   Bundles the beam-position inputs, the CPU-cycle strobe, the controller
//   activity flag and the request outputs of hdma_trigger_gen.
//   slave  : view used by the trigger generator (beam/strobe in, requests out)
//   master : view used by whatever drives the beam and consumes the requests
//
//   dot_en      one-clk strobe per PPU dot
//   h_cnt       current dot 0..339
//   v_cnt       current line 0..261
//   overscan    PPU overscan mode
//   cpu_en      CPU-cycle strobe shared with the DMA controller
//   hdma_active high while an HDMA pass runs in the controller
//   hdma_init   one-clk frame init request
//   hdma_start  one-clk line request
//   pending     a request is latched and not yet delivered
//   miss_count  saturating count of dropped line requests
interface hdma_trigger_gen_if;
  logic       dot_en;
  logic [8:0] h_cnt;
  logic [8:0] v_cnt;
  logic       overscan;
  logic       cpu_en;
  logic       hdma_active;
  logic       hdma_init;
  logic       hdma_start;
  logic       pending;
  logic [7:0] miss_count;

  modport slave (
    input  dot_en, h_cnt, v_cnt, overscan, cpu_en, hdma_active,
    output hdma_init, hdma_start, pending, miss_count
  );

  modport master (
    output dot_en, h_cnt, v_cnt, overscan, cpu_en, hdma_active,
    input  hdma_init, hdma_start, pending, miss_count
  );
endinterface

// File: rtl/hdma_trigger_gen.sv
// hdma_trigger_gen
//   Turns the PPU beam position into HDMA request pulses for the DMA
//   controller: one init request per frame (line 0, dot H_INIT) and one line
//   request per visible line (dot H_LINE). Requests are held until a CPU-cycle
//   strobe and delivered as one-clk registered pulses launched by the clock
//   edge that closes a cpu_en clk. While a previous pass is still in flight,
//   line requests are dropped (and counted) and an init request is deferred.
//
//   Ports:
//     clk     system clock
//     reset   synchronous, active-high
//     io_bus  hdma_trigger_gen_if.slave (beam, cpu_en, hdma_active in;
//             hdma_init, hdma_start, pending, miss_count out)
//
//   Build option:
//     HDMA_MISS_CNT_EN  when defined, miss_count is a saturating 8-bit
//                       counter of dropped requests; otherwise it is tied
//                       to zero and no counter flops exist.
module hdma_trigger_gen #(
  parameter int H_INIT          = 6,
  parameter int H_LINE          = 276,
  parameter int V_LAST_NORMAL   = 224,
  parameter int V_LAST_OVERSCAN = 239
) (
  input logic                 clk,
  input logic                 reset,
  hdma_trigger_gen_if.slave   io_bus
);

  localparam logic [8:0] LP_H_INIT   = 9'(H_INIT);
  localparam logic [8:0] LP_H_LINE   = 9'(H_LINE);
  localparam logic [8:0] LP_V_NORMAL = 9'(V_LAST_NORMAL);
  localparam logic [8:0] LP_V_OVSCAN = 9'(V_LAST_OVERSCAN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND_INIT,
    S_PEND_LINE,
    S_WAIT_ACT,
    S_RUN
  } state_t;

  state_t     r_state;
  logic       r_defer;       // init arrived while a pass was in flight
  logic       r_wcnt;        // one quiet cpu_en already seen in WAIT_ACT
  logic [8:0] r_v_last;
  logic       r_hdma_init;
  logic       r_hdma_start;

  logic       w_ev_init;
  logic       w_ev_line;
  logic       w_frame_top;
  logic       w_release;
  state_t     w_state_base;
  logic       w_defer_base;
  logic       w_wcnt_base;
  logic       w_fire_init_base;
  logic       w_fire_start_base;
  state_t     w_state_nxt;
  logic       w_defer_nxt;
  logic       w_wcnt_nxt;
  logic       w_init_nxt;
  logic       w_start_nxt;

  assign w_frame_top = io_bus.dot_en && (io_bus.v_cnt == 9'd0) && (io_bus.h_cnt == 9'd0);
  assign w_ev_init   = io_bus.dot_en && (io_bus.v_cnt == 9'd0) && (io_bus.h_cnt == LP_H_INIT);
  assign w_ev_line   = io_bus.dot_en && (io_bus.v_cnt <= r_v_last) && (io_bus.h_cnt == LP_H_LINE);

  // Progress of the current state, ignoring this clk's beam events.
  always_comb begin
    w_state_base      = r_state;
    w_defer_base      = r_defer;
    w_wcnt_base       = r_wcnt;
    w_fire_init_base  = 1'b0;
    w_fire_start_base = 1'b0;
    w_release         = 1'b0;
    unique case (r_state)
      S_PEND_INIT: begin
        if (io_bus.cpu_en) begin
          w_fire_init_base = 1'b1;
          w_state_base     = S_WAIT_ACT;
          w_wcnt_base      = 1'b0;
        end
      end
      S_PEND_LINE: begin
        if (io_bus.cpu_en) begin
          w_fire_start_base = 1'b1;
          w_state_base      = S_WAIT_ACT;
          w_wcnt_base       = 1'b0;
        end
      end
      S_WAIT_ACT: begin
        // A controller with every channel disabled never raises hdma_active;
        // give up after the second quiet CPU cycle.
        if (io_bus.hdma_active) begin
          w_state_base = S_RUN;
        end else if (io_bus.cpu_en) begin
          if (r_wcnt) w_release = 1'b1;
          else        w_wcnt_base = 1'b1;
        end
      end
      S_RUN: begin
        if (!io_bus.hdma_active) w_release = 1'b1;
      end
      default: ;
    endcase
    if (w_release) begin
      w_state_base = r_defer ? S_PEND_INIT : S_IDLE;
      w_defer_base = 1'b0;
    end
  end

  // Beam events are applied to the state we are about to enter, so an event
  // landing on the exit clk is never lost. A request that becomes pending on
  // a cpu_en clk is delivered at once.
  always_comb begin
    w_state_nxt = w_state_base;
    w_defer_nxt = w_defer_base;
    w_wcnt_nxt  = w_wcnt_base;
    w_init_nxt  = w_fire_init_base;
    w_start_nxt = w_fire_start_base;
    if (w_ev_init) begin
      unique case (w_state_base)
        S_IDLE, S_PEND_LINE: w_state_nxt = S_PEND_INIT;
        S_WAIT_ACT, S_RUN:   w_defer_nxt = 1'b1;
        default: ;
      endcase
    end
    if (w_ev_line && (w_state_base == S_IDLE)) w_state_nxt = S_PEND_LINE;
    if (io_bus.cpu_en && !w_fire_init_base && !w_fire_start_base) begin
      if (w_state_nxt == S_PEND_INIT) begin
        w_init_nxt  = 1'b1;
        w_state_nxt = S_WAIT_ACT;
        w_wcnt_nxt  = 1'b0;
      end else if (w_state_nxt == S_PEND_LINE) begin
        w_start_nxt = 1'b1;
        w_state_nxt = S_WAIT_ACT;
        w_wcnt_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_defer      <= 1'b0;
      r_wcnt       <= 1'b0;
      r_v_last     <= LP_V_NORMAL;
      r_hdma_init  <= 1'b0;
      r_hdma_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_defer      <= w_defer_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_hdma_init  <= w_init_nxt;
      r_hdma_start <= w_start_nxt;
      // Overscan only takes effect at the top of a frame.
      if (w_frame_top) r_v_last <= io_bus.overscan ? LP_V_OVSCAN : LP_V_NORMAL;
    end
  end

  assign io_bus.hdma_init  = r_hdma_init;
  assign io_bus.hdma_start = r_hdma_start;
  assign io_bus.pending    = (r_state == S_PEND_INIT) || (r_state == S_PEND_LINE) || r_defer;

`ifdef HDMA_MISS_CNT_EN
  logic       w_miss;
  logic [7:0] r_miss_count;

  // A line event that finds anything but IDLE is dropped; an init event that
  // replaces a waiting line request drops that line request.
  assign w_miss = (w_ev_line && (w_state_base != S_IDLE)) ||
                  (w_ev_init && (w_state_base == S_PEND_LINE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_miss_count <= 8'h00;
    end else if (w_miss && (r_miss_count != 8'hFF)) begin
      r_miss_count <= r_miss_count + 8'd1;
    end
  end

  assign io_bus.miss_count = r_miss_count;
`else
  assign io_bus.miss_count = 8'h00;
`endif

endmodule

// File: tb/tb_hdma_trigger_gen.sv
module tb_hdma_trigger_gen;
  logic clk = 1'b0;
  logic reset;

  hdma_trigger_gen_if bus ();

  hdma_trigger_gen dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

`ifdef HDMA_MISS_CNT_EN
  localparam int EXP_MISS2 = 2;
`else
  localparam int EXP_MISS2 = 0;
`endif

  int checks = 0;
  int errors = 0;

  // stimulus control
  int stall_cnt  = 0;
  bit stall_hold = 0;
  int phase      = 0;
  int act_mode   = 0;   // 0: controller answers each request, 1: never active
  bit act_force  = 0;
  int tmr        = 0;
  int scen       = 0;

  // pulse bookkeeping
  int cur_line    = 0;
  int frame_vlast = 224;
  int cnt_init, cnt_start, cnt_late;
  int line_start [0:261];
  bit ev5         = 0;
  int ev5_pulses  = 0;

  // behavioural model: a request slot, an in-flight pass, a deferred init
  int m_req      = 0;   // 0 none, 1 init waiting, 2 line waiting
  bit m_defer    = 0;
  bit m_inflight = 0;
  bit m_saw      = 0;
  int m_quiet    = 0;
  int m_miss     = 0;
  int m_vlast    = 224;
  bit m_init     = 0;
  bit m_start    = 0;
  bit mi_ei, mi_el, mi_fi, mi_fs, mi_drop, mi_done;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // CPU-cycle strobe: one clk in six, suppressible
  initial begin
    bus.cpu_en = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        stall_cnt--;
        bus.cpu_en = 1'b0;
      end else if (stall_hold) begin
        bus.cpu_en = 1'b0;
      end else begin
        bus.cpu_en = (phase == 5);
      end
      phase = (phase == 5) ? 0 : phase + 1;
    end
  end

  // Controller stand-in: runs a 3-clk pass a few clks after each request
  initial begin
    bus.hdma_active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.hdma_init || bus.hdma_start) tmr = 1;
      else if (tmr > 0 && tmr < 6)         tmr++;
      else                                 tmr = 0;
      bus.hdma_active = act_force || (act_mode == 0 && tmr >= 4);
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_req = 0; m_defer = 0; m_inflight = 0; m_saw = 0; m_quiet = 0;
      m_miss = 0; m_vlast = 224; m_init = 0; m_start = 0;
    end else begin
      mi_ei = bus.dot_en && bus.v_cnt == 9'd0 && bus.h_cnt == 9'd6;
      mi_el = bus.dot_en && bus.h_cnt == 9'd276 && int'(bus.v_cnt) <= m_vlast;
      mi_fi = 0; mi_fs = 0; mi_drop = 0; mi_done = 0;
      if (m_req != 0 && bus.cpu_en) begin
        mi_fi = (m_req == 1); mi_fs = (m_req == 2);
        m_req = 0; m_inflight = 1; m_saw = 0; m_quiet = 0;
      end else if (m_inflight) begin
        if (!m_saw) begin
          if (bus.hdma_active) m_saw = 1;
          else if (bus.cpu_en) begin
            m_quiet++;
            mi_done = (m_quiet == 2);
          end
        end else begin
          mi_done = !bus.hdma_active;
        end
        if (mi_done) begin
          m_inflight = 0;
          if (m_defer) begin m_defer = 0; m_req = 1; end
        end
      end
      if (mi_ei) begin
        if (m_inflight) m_defer = 1;
        else begin
          if (m_req == 2) mi_drop = 1;
          m_req = 1;
        end
      end
      if (mi_el) begin
        if (m_inflight || m_req != 0) mi_drop = 1;
        else m_req = 2;
      end
      if (m_req != 0 && bus.cpu_en && !mi_fi && !mi_fs) begin
        mi_fi = (m_req == 1); mi_fs = (m_req == 2);
        m_req = 0; m_inflight = 1; m_saw = 0; m_quiet = 0;
      end
`ifdef HDMA_MISS_CNT_EN
      if (mi_drop && m_miss < 255) m_miss++;
`endif
      if (bus.dot_en && bus.v_cnt == 9'd0 && bus.h_cnt == 9'd0)
        m_vlast = bus.overscan ? 239 : 224;
      m_init  = mi_fi;
      m_start = mi_fs;
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("hdma_init",  bus.hdma_init,  m_init);
    chk("hdma_start", bus.hdma_start, m_start);
    chk("pending",    bus.pending,    (m_req != 0 || m_defer) ? 1 : 0);
    chk("miss_count", bus.miss_count, m_miss);
    if (ev5 && stall_cnt > 0) chk("pending_during_stall", bus.pending, 1);
    if (bus.hdma_init) cnt_init++;
    if (bus.hdma_start) begin
      cnt_start++;
      line_start[cur_line]++;
      if (cur_line > frame_vlast) cnt_late++;
      if (ev5) begin
        ev5_pulses++;
        chk("line5_pulse_after_stall", (stall_cnt == 0) ? 1 : 0, 1);
        ev5 = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic dot(input int h, input int n);
    bus.dot_en = 1'b1;
    bus.h_cnt  = 9'(h);
    @(posedge clk); #1;
    bus.dot_en = 1'b0;
    idle(n);
  endtask

  task automatic start_frame(input int vlast);
    cnt_init = 0; cnt_start = 0; cnt_late = 0;
    for (int i = 0; i < 262; i++) line_start[i] = 0;
    frame_vlast = vlast;
  endtask

  task automatic run_line(input int v);
    cur_line  = v;
    bus.v_cnt = 9'(v);
    if (scen == 2 && v == 10) act_force = 1;
    if (scen == 2 && v == 13) act_force = 0;
    if (scen == 6 && v == 3)  stall_hold = 1;
    dot(0, 1);
    dot(6, 0);
    if (scen == 5 && v == 5) stall_cnt = 50;
    idle(24);
    dot(276, 0);
    if (scen == 5 && v == 5) ev5 = 1;
    if (scen == 6 && v == 3) begin
      idle(2);
      @(negedge clk);
      chk("pend_line_before_reset", bus.pending, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("reset_mid_start",   bus.hdma_start, 0);
      chk("reset_mid_pending", bus.pending,    0);
      chk("reset_mid_miss",    bus.miss_count, 0);
      @(posedge clk); #1;
      reset      = 1'b0;
      stall_hold = 0;
    end
    idle(6);
    dot(339, 1);
    if (scen == 5 && v == 5) idle(40);
  endtask

  initial begin
    reset        = 1'b1;
    bus.dot_en   = 1'b0;
    bus.h_cnt    = 9'd0;
    bus.v_cnt    = 9'd0;
    bus.overscan = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_init",    bus.hdma_init,  0);
    chk("rst_start",   bus.hdma_start, 0);
    chk("rst_pending", bus.pending,    0);
    chk("rst_miss",    bus.miss_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3);

    // frame 0: normal timing, overscan raised mid-frame
    scen = 1; act_mode = 0;
    start_frame(224);
    for (int v = 0; v < 262; v++) begin
      if (v == 100) bus.overscan = 1'b1;
      run_line(v);
    end
    chk("f0_init_count",  cnt_init,  1);
    chk("f0_start_count", cnt_start, 225);
    chk("f0_vblank_starts", cnt_late, 0);
    chk("f0_line224", line_start[224], 1);
    chk("f0_miss", bus.miss_count, 0);

    // frame 1: overscan latched, lines 0..239
    start_frame(239);
    for (int v = 0; v < 262; v++) begin
      if (v == 100) bus.overscan = 1'b0;
      run_line(v);
    end
    chk("f1_init_count",  cnt_init,  1);
    chk("f1_start_count", cnt_start, 240);
    chk("f1_line239", line_start[239], 1);
    chk("f1_vblank_starts", cnt_late, 0);

    // frame 2: controller busy from line 10 through line 12
    scen = 2;
    start_frame(224);
    for (int v = 0; v < 262; v++) run_line(v);
    chk("f2_line10", line_start[10], 1);
    chk("f2_line11", line_start[11], 0);
    chk("f2_line12", line_start[12], 0);
    chk("f2_line13", line_start[13], 1);
    chk("f2_start_count", cnt_start, 223);
    chk("f2_miss", bus.miss_count, EXP_MISS2);

    // frame 3: controller never goes active
    scen = 3; act_mode = 1;
    start_frame(224);
    for (int v = 0; v < 262; v++) run_line(v);
    chk("f3_init_count",  cnt_init,  1);
    chk("f3_start_count", cnt_start, 225);
    chk("f3_miss", bus.miss_count, EXP_MISS2);
    act_mode = 0;

    // frame 4 (partial): cpu_en held off around the line 5 event
    scen = 5;
    start_frame(224);
    for (int v = 0; v < 8; v++) run_line(v);
    chk("f4_line5_pulses", ev5_pulses, 1);
    chk("f4_start_count", cnt_start, 8);

    // frame 5 (partial): reset while a line request waits
    scen = 6;
    start_frame(224);
    for (int v = 0; v < 6; v++) run_line(v);
    chk("f5_line3_no_pulse", line_start[3], 0);
    chk("f5_line4", line_start[4], 1);

    // next frame: init still issued
    start_frame(224);
    for (int v = 0; v < 2; v++) run_line(v);
    chk("f6_init_count", cnt_init, 1);
    chk("f6_line0", line_start[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
